// File: rtl/pipe_stage_skid_register.sv
// Pipeline stage register with valid/ready handshake, 2-entry skid buffer and synchronous flush.
// Optional stall counter is compiled in when the PIPE_STALL_CNT_EN macro is defined.
module pipe_stage_skid_register #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef PIPE_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state;
    logic             m_valid;
    logic             s_valid;
    logic             rdy_q;
    logic [WIDTH-1:0] m_data;
    logic [WIDTH-1:0] s_data;
    logic             in_fire;
    logic             out_fire;

    if (WIDTH < 1 || CNT_W < 1) begin : g_bad_param
        $error("pipe_stage_skid_register: WIDTH and CNT_W must be >= 1");
    end

    assign out_valid = m_valid;
    assign out_data  = m_data;
    assign in_ready  = rdy_q;
    assign in_fire   = in_valid & rdy_q;
    assign out_fire  = m_valid & out_ready;

    // m_valid/s_valid/rdy_q are kept alongside the state so every output is a flop
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= EMPTY;
            m_valid <= 1'b0;
            s_valid <= 1'b0;
            rdy_q   <= 1'b1;
            m_data  <= '0;
            s_data  <= '0;
        end else if (clear) begin
            state   <= EMPTY;
            m_valid <= 1'b0;
            s_valid <= 1'b0;
            rdy_q   <= 1'b1;
            m_data  <= '0;
            s_data  <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        state   <= ONE;
                        m_valid <= 1'b1;
                        m_data  <= in_data;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        m_data <= in_data;
                    end else if (in_fire) begin
                        state   <= FULL;
                        s_valid <= 1'b1;
                        s_data  <= in_data;
                        rdy_q   <= 1'b0;
                    end else if (out_fire) begin
                        state   <= EMPTY;
                        m_valid <= 1'b0;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        state   <= ONE;
                        s_valid <= 1'b0;
                        m_data  <= s_data;
                        rdy_q   <= 1'b1;
                    end
                end
                default: begin
                    state   <= EMPTY;
                    m_valid <= 1'b0;
                    s_valid <= 1'b0;
                    rdy_q   <= 1'b1;
                end
            endcase
        end
    end

`ifdef PIPE_STALL_CNT_EN
    // Flush leaves the count alone; only reset clears it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (m_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end
`endif

endmodule
